// File: rtl/led_chaser8_if.sv
// Control and status bundle for led_chaser8. The master drives the controls;
// the slave (the chaser) returns registered position/LED state and debug state.
interface led_chaser8_if;
  // Handshake: none. en/mode/load/load_pos are level controls that the chaser
  // samples on every rising clk edge. All returned signals are registers.
  logic        en;
  logic [1:0]  mode;
  logic        load;
  logic [2:0]  load_pos;
  logic [2:0]  pos;
  logic [7:0]  led;
  logic        step_pulse;
  logic        wrap;
  logic        dbg_dir;        // 1 = up, 0 = down
  logic [15:0] dbg_prescaler;  // zero-extended prescaler count

  modport master (
    output en, mode, load, load_pos,
    input  pos, led, step_pulse, wrap, dbg_dir, dbg_prescaler
  );

  modport slave (
    input  en, mode, load, load_pos,
    output pos, led, step_pulse, wrap, dbg_dir, dbg_prescaler
  );
endinterface

// File: rtl/led_chaser8.sv
// Eight-position LED chaser: prescaled step engine (down/up/bounce/hold) with load
// and registered one-hot LED drive. Define LED_CHASER_TRAIL_EN to also light the previous position.
module led_chaser8 #(
  parameter int DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  led_chaser8_if.slave  bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_DOWN   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  logic [PW-1:0] r_ps;
  logic [2:0]    r_pos;
  logic [7:0]    r_led;
  logic          r_step;
  logic          r_wrap;
  dir_e          r_dir;
`ifdef LED_CHASER_TRAIL_EN
  logic [2:0]    r_prev;
`endif

  mode_e       w_mode;
  logic        w_tick;
  logic [2:0]  w_next_pos;
  logic        w_next_wrap;
  dir_e        w_next_dir;
  logic [7:0]  w_step_led;
  logic [7:0]  w_load_led;

  function automatic logic [7:0] onehot(input logic [2:0] p);
    return 8'b0000_0001 << p;
  endfunction

  assign w_mode = mode_e'(bus.mode);
  assign w_tick = bus.en && (w_mode != MODE_HOLD) && (r_ps == PS_LAST);

  always_comb begin
    w_next_pos  = r_pos;
    w_next_wrap = 1'b0;
    w_next_dir  = r_dir;
    case (w_mode)
      MODE_DOWN: begin
        w_next_pos  = r_pos - 3'd1;
        w_next_wrap = (r_pos == 3'd0);
      end
      MODE_UP: begin
        w_next_pos  = r_pos + 3'd1;
        w_next_wrap = (r_pos == 3'd7);
      end
      MODE_BOUNCE: begin
        // Reversal happens on the tick that finds pos at the end, so a load of an end value is legal.
        if (r_dir == DIR_UP) begin
          if (r_pos == 3'd7) begin
            w_next_pos  = 3'd6;
            w_next_wrap = 1'b1;
            w_next_dir  = DIR_DOWN;
          end else begin
            w_next_pos = r_pos + 3'd1;
          end
        end else begin
          if (r_pos == 3'd0) begin
            w_next_pos  = 3'd1;
            w_next_wrap = 1'b1;
            w_next_dir  = DIR_UP;
          end else begin
            w_next_pos = r_pos - 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef LED_CHASER_TRAIL_EN
  assign w_step_led = onehot(w_next_pos) | onehot(r_pos);
`else
  assign w_step_led = onehot(w_next_pos);
`endif
  assign w_load_led = onehot(bus.load_pos);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ps   <= '0;
      r_pos  <= 3'd0;
      r_led  <= 8'h01;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      r_dir  <= DIR_UP;
`ifdef LED_CHASER_TRAIL_EN
      r_prev <= 3'd0;
`endif
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      if (bus.load) begin
        r_pos <= bus.load_pos;
        r_ps  <= '0;
        r_led <= w_load_led;
`ifdef LED_CHASER_TRAIL_EN
        r_prev <= bus.load_pos;
`endif
      end else begin
        if (w_mode == MODE_HOLD) begin
          r_ps <= '0;
        end else if (bus.en) begin
          r_ps <= (r_ps == PS_LAST) ? '0 : r_ps + 1'b1;
        end
        if (w_tick) begin
          r_pos  <= w_next_pos;
          r_dir  <= w_next_dir;
          r_led  <= w_step_led;
          r_step <= 1'b1;
          r_wrap <= w_next_wrap;
`ifdef LED_CHASER_TRAIL_EN
          r_prev <= r_pos;
`endif
        end
      end
    end
  end

  assign bus.pos           = r_pos;
  assign bus.led           = r_led;
  assign bus.step_pulse    = r_step;
  assign bus.wrap          = r_wrap;
  assign bus.dbg_dir       = (r_dir == DIR_UP);
  assign bus.dbg_prescaler = 16'(r_ps);

endmodule

// File: tb/tb_led_chaser8.sv
// Self-checking bench for led_chaser8 (DIV=4): reference model compared every
// cycle, plus directed literal checks. Honours LED_CHASER_TRAIL_EN when defined.
module tb_led_chaser8;
  localparam int DIV = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_on   = 1'b0;

  led_chaser8_if bus ();

  led_chaser8 #(.DIV(DIV)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Position lives on a ring of 8; bounce walks by +/-1 and reflects off the ends.
  int m_pos = 0, m_prev = 0, m_cnt = 0, m_up = 1;
  bit m_step = 0, m_wrap = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = 0; m_prev = 0; m_cnt = 0; m_up = 1; m_step = 0; m_wrap = 0;
    end else begin
      m_step = 0;
      m_wrap = 0;
      if (bus.load) begin
        m_pos = int'(bus.load_pos); m_prev = m_pos; m_cnt = 0;
      end else if (bus.mode == 2'd3) begin
        m_cnt = 0;
      end else if (bus.en) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == DIV) begin
          m_cnt  = 0;
          m_step = 1;
          m_prev = m_pos;
          if (bus.mode == 2'd0) begin
            m_wrap = (m_pos == 0);
            m_pos  = (m_pos + 7) % 8;
          end else if (bus.mode == 2'd1) begin
            m_wrap = (m_pos == 7);
            m_pos  = (m_pos + 1) % 8;
          end else begin
            int nxt;
            nxt = m_up ? m_pos + 1 : m_pos - 1;
            if (nxt > 7 || nxt < 0) begin
              m_up   = 1 - m_up;
              nxt    = m_up ? m_pos + 1 : m_pos - 1;
              m_wrap = 1;
            end
            m_pos = nxt;
          end
        end
      end
    end
  end

  function automatic logic [7:0] model_led();
    logic [7:0] l;
    l = 8'd1 << m_pos;
`ifdef LED_CHASER_TRAIL_EN
    l = l | (8'd1 << m_prev);
`endif
    return l;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_pos",  16'(bus.pos),        16'(m_pos));
      check("model_led",  16'(bus.led),        16'(model_led()));
      check("model_step", 16'(bus.step_pulse), 16'(m_step));
      check("model_wrap", 16'(bus.wrap),       16'(m_wrap));
      check("model_dir",  16'(bus.dbg_dir),    16'(m_up));
      check("model_ps",   bus.dbg_prescaler,   16'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_step(input string name);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.step_pulse && k < 3 * DIV + 2);
    if (!bus.step_pulse) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no step after %0d cycles, required a step", name, k);
    end
  endtask

  task automatic do_load(input logic [2:0] p, input logic [1:0] md);
    bus.load = 1'b1; bus.load_pos = p; bus.mode = md;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  function automatic logic [15:0] exp_led(input int p, input int prev);
    logic [7:0] l;
    l = 8'd1 << p;
`ifdef LED_CHASER_TRAIL_EN
    l = l | (8'd1 << prev);
`else
    if (prev < 0) l = l;
`endif
    return 16'(l);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.mode = 2'd0; bus.load = 1'b0; bus.load_pos = 3'd0;
    cycles(2);
    cmp_on = 1'b1;
    check("rst_pos",  16'(bus.pos),        16'd0);
    check("rst_led",  16'(bus.led),        16'h01);
    check("rst_step", 16'(bus.step_pulse), 16'd0);
    check("rst_wrap", 16'(bus.wrap),       16'd0);

    // Down-wrap from reset: steps on enabled edges 4, 8, 12
    rst = 1'b0; bus.en = 1'b1; bus.mode = 2'd0;
    cycles(3);
    check("down_nostep_e3", 16'(bus.step_pulse), 16'd0);
    cycles(1);
    check("down_pos_e4",  16'(bus.pos),  16'd7);
    check("down_wrap_e4", 16'(bus.wrap), 16'd1);
    check("down_led_e4",  16'(bus.led),  exp_led(7, 0));
    cycles(4);
    check("down_pos_e8",  16'(bus.pos),  16'd6);
    check("down_wrap_e8", 16'(bus.wrap), 16'd0);
    cycles(4);
    check("down_pos_e12", 16'(bus.pos),  16'd5);

    // Up-wrap after a load of 6
    do_load(3'd6, 2'd1);
    check("load6_pos",  16'(bus.pos),        16'd6);
    check("load6_step", 16'(bus.step_pulse), 16'd0);
    check("load6_led",  16'(bus.led),        16'h40);
    wait_step("up_step1");
    check("up_pos7", 16'(bus.pos), 16'd7);
    check("up_led7", 16'(bus.led), exp_led(7, 6));
    wait_step("up_step2");
    check("up_pos0",  16'(bus.pos),  16'd0);
    check("up_wrap0", 16'(bus.wrap), 16'd1);
    check("up_led0",  16'(bus.led),  exp_led(0, 7));

    // Bounce from 5 going up: 6, 7, 6(wrap), 5..0, 1(wrap)
    do_load(3'd5, 2'd2);
    for (int i = 0; i < 3; i++) wait_step("bnc_a");
    check("bnc_pos6",  16'(bus.pos),     16'd6);
    check("bnc_wrap6", 16'(bus.wrap),    16'd1);
    check("bnc_dir6",  16'(bus.dbg_dir), 16'd0);
    for (int i = 0; i < 7; i++) wait_step("bnc_b");
    check("bnc_pos1",  16'(bus.pos),     16'd1);
    check("bnc_wrap1", 16'(bus.wrap),    16'd1);
    check("bnc_dir1",  16'(bus.dbg_dir), 16'd1);

    // en dropped at prescaler 2 freezes the count
    cycles(2);
    check("en_ps2", bus.dbg_prescaler, 16'd2);
    bus.en = 1'b0;
    cycles(10);
    check("en_frozen_ps",  bus.dbg_prescaler, 16'd2);
    check("en_frozen_pos", 16'(bus.pos),      16'd1);
    bus.en = 1'b1;
    cycles(1);
    check("en_resume_nostep", 16'(bus.step_pulse), 16'd0);
    cycles(1);
    check("en_resume_step", 16'(bus.step_pulse), 16'd1);
    check("en_resume_pos",  16'(bus.pos),        16'd2);

    // Load on a tick edge wins
    cycles(3);
    check("ldtick_ps3", bus.dbg_prescaler, 16'd3);
    do_load(3'd5, 2'd2);
    check("ldtick_pos",  16'(bus.pos),        16'd5);
    check("ldtick_step", 16'(bus.step_pulse), 16'd0);
    check("ldtick_ps",   bus.dbg_prescaler,   16'd0);

    // Hold mode
    bus.mode = 2'd3;
    cycles(20);
    check("hold_pos", 16'(bus.pos),      16'd5);
    check("hold_ps",  bus.dbg_prescaler, 16'd0);

    // Up from 3: trail shows two adjacent LEDs when enabled
    do_load(3'd3, 2'd1);
    check("tr_load_led", 16'(bus.led), 16'h08);
    wait_step("tr_step1");
    check("tr_led4", 16'(bus.led), exp_led(4, 3));
    wait_step("tr_step2");
    check("tr_led5", 16'(bus.led), exp_led(5, 4));

    // Async reset mid-bounce
    do_load(3'd7, 2'd2);
    wait_step("ar_step");
    check("ar_pre_dir", 16'(bus.dbg_dir), 16'd0);
    cycles(1);
    #2 rst = 1'b1;
    #1;
    check("ar_pos",  16'(bus.pos),        16'd0);
    check("ar_led",  16'(bus.led),        16'h01);
    check("ar_step", 16'(bus.step_pulse), 16'd0);
    check("ar_wrap", 16'(bus.wrap),       16'd0);
    check("ar_dir",  16'(bus.dbg_dir),    16'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_step("ar_after");
    check("ar_after_pos",  16'(bus.pos),  16'd1);
    check("ar_after_wrap", 16'(bus.wrap), 16'd0);
    cycles(2);

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_chaser8.md
# led_chaser8

Eight-position LED chaser for the led_light design. A prescaled step engine moves a 3-bit position down (7→0 wrap), up (0→7 wrap) or back and forth, and decodes it into a registered one-hot LED drive. The block is the counting-up and decoding partner of the existing 3-bit down counter: it adds direction control, load and pacing, and drives the LEDs directly.

## Interface
- DIV, 4: clock cycles per step while enabled; legal range ≥1; prescaler width is max(1, $clog2(DIV)).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  prescaler/step enable.
- mode  in  2  00 down-wrap, 01 up-wrap, 10 bounce, 11 hold.
- load  in  1  synchronous load strobe.
- load_pos  in  3  value loaded into pos.
- pos  out  3  current position, registered.
- led  out  8  one-hot of pos (led[pos]=1), registered.
- step_pulse  out  1  high for one cycle when pos has just stepped.
- wrap  out  1  high for one cycle when the step was a wrap or a bounce reversal.

## Operation
- Reset values: pos=0, led=8'h01, step_pulse=0, wrap=0, prescaler=0, dir=up.
- Prescaler:
  - Counts 0..DIV-1 on each edge with en=1 and mode≠11.
  - Holds its value when en=0.
  - Clears to 0 when mode=11.
  - tick = en && mode≠11 && prescaler==DIV-1.
- On tick, pos advances per mode:
  - 00: pos-1, 0→7 with wrap=1.
  - 01: pos+1, 7→0 with wrap=1.
  - 10: move in dir. At pos 7 with dir=up: dir←down, pos←6, wrap=1. At pos 0 with dir=down: dir←up, pos←1, wrap=1.
- dir changes only in bounce mode. Leaving and re-entering bounce resumes with the stored dir.
- Load has priority over tick:
  - pos←load_pos, prescaler←0, dir unchanged.
  - step_pulse and wrap stay 0.
  - led follows the new pos.
- In bounce mode, a load of 7 with dir=up (or 0 with dir=down) is legal. The next tick performs the reversal.
- Modes 00/01 never alter dir.

## Timing
- Each output is a plain register; no combinational path from any input to any output.
- Step edge: the edge where tick=1. On that edge pos, led, step_pulse and wrap update together. The following edge clears step_pulse and wrap unless it is itself a step edge.
- With en held high from reset release, steps occur on enabled edges DIV, 2·DIV, 3·DIV, …
- DIV=1: every enabled edge is a step edge, so step_pulse stays high continuously.
- en deasserted mid-count freezes the prescaler. On re-enable, the count resumes without restarting.
- A mode change takes effect on the next tick. It does not clear the prescaler, except when entering 11.
- load and tick on the same edge: load wins; no step occurs.
- Asserting reset mid-step immediately forces all reset values, regardless of clk.

## Configuration
- LED_CHASER_TRAIL_EN defined: led = one-hot(pos) | one-hot(prev_pos).
  - prev_pos is updated to the old pos on each step edge.
  - On load, prev_pos is set to load_pos, so a single LED is lit.
  - prev_pos resets to 0, so led=8'h01 after reset.
- LED_CHASER_TRAIL_EN undefined: led is strictly one-hot(pos) and there is no prev_pos register.

## Test plan
- Reset → pos=0, led=8'h01, step_pulse=0, wrap=0. DIV=4, mode=00, en=1 → steps on edges 4, 8, 12; pos sequence 7, 6, 5; wrap=1 only on the 0→7 step.
- mode=01, load_pos=6, load pulse, then steps → pos 7, then 0 with wrap=1; led tracks 8'h80, then 8'h01.
- mode=10 from pos 5, dir=up → pos 6, 7, 6(wrap=1), 5 … 0, 1(wrap=1).
- en dropped for 10 cycles at prescaler=2, then restored → next step comes 2 enabled edges later. load asserted on a tick edge → pos=load_pos, step_pulse=0.
- mode=11 for 20 cycles → pos constant, prescaler 0. With LED_CHASER_TRAIL_EN, steps from pos 3 in mode 01 → led 8'h18, then 8'h30.
- Async reset pulsed between clock edges mid-bounce → outputs return to reset values immediately; dir=up afterwards.
